// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the zero word used for register resets.
package mul_div_unit_pkg;

    // Operation encodings driven by the EX stage; 7 is reserved and decodes as NONE.
    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam logic [31:0] ZERO_WORD = 32'd0;

    // Controller states; exported on o_state for observation.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Iterative radix-2 restoring divider working on operand magnitudes.
// One quotient bit per cycle for exactly 32 cycles; o_done is high in the
// last cycle with the sign-corrected results presented combinationally, so
// the caller can capture them at the edge that ends the operation.
module div_core
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_cancel,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_done
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_dvd_neg = i_signed & i_dividend[31];
    assign w_dvs_neg = i_signed & i_divisor[31];
    assign w_dvd_mag = w_dvd_neg ? (ZERO_WORD - i_dividend) : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? (ZERO_WORD - i_divisor) : i_divisor;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // The partial remainder is always below the divisor, so bit 32 of the
    // difference is a clean "went negative" flag.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_next = {r_quo[30:0], ~w_diff[32]};

    assign o_done      = r_busy & (r_cnt == 5'd31);
    assign o_quotient  = r_neg_q ? (ZERO_WORD - w_quo_next) : w_quo_next;
    assign o_remainder = r_neg_r ? (ZERO_WORD - w_rem_next) : w_rem_next;

    // Capture magnitudes and result signs on start, then iterate until count 31.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= ZERO_WORD;
            r_quo   <= ZERO_WORD;
            r_dvs   <= ZERO_WORD;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_cancel) begin
            r_busy <= 1'b0;
            r_cnt  <= 5'd0;
        end else if (i_start) begin
            r_rem   <= ZERO_WORD;
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit. Multiplies take one cycle on registered
// operands, divides are delegated to div_core, MTHI/MTLO write directly.
// stall holds the front of the pipe while a result is being produced; the
// one-cycle DONE state lets the still-present instruction retire without
// re-triggering.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_t  o_state
);

    mdu_state_t         r_state;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic signed [32:0] r_ma;
    logic signed [32:0] r_mb;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_div_start;
    logic               w_div_signed;
    logic               w_div_done;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic signed [63:0] w_prod;

    assign w_is_mul     = (op == MDU_MULT) | (op == MDU_MULTU);
    assign w_is_div     = (op == MDU_DIV)  | (op == MDU_DIVU);
    assign w_div_signed = (op == MDU_DIV);
    assign w_div_start  = (r_state == ST_IDLE) & start & ~flush & w_is_div & (db != ZERO_WORD);

    // Low 64 bits of the 33x33 signed product of the extended operands.
    assign w_prod = r_ma * r_mb;

    assign stall = ~rst & ~flush &
                   (((r_state == ST_IDLE) & start & (w_is_mul | w_is_div)) |
                    (r_state == ST_MUL) | (r_state == ST_DIV));

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign o_state = r_state;

    div_core u_div_core (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_signed    (w_div_signed),
        .i_dividend  (da),
        .i_divisor   (db),
        .i_cancel    (flush),
        .o_quotient  (w_quot),
        .o_remainder (w_rem),
        .o_done      (w_div_done)
    );

    // Controller FSM plus the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hi    <= ZERO_WORD;
            r_lo    <= ZERO_WORD;
            r_ma    <= '0;
            r_mb    <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT: begin
                                r_ma    <= {da[31], da};
                                r_mb    <= {db[31], db};
                                r_state <= ST_MUL;
                            end
                            MDU_MULTU: begin
                                r_ma    <= {1'b0, da};
                                r_mb    <= {1'b0, db};
                                r_state <= ST_MUL;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                r_state <= (db != ZERO_WORD) ? ST_DIV : ST_DONE;
                            end
                            MDU_MTHI: r_hi <= da;
                            MDU_MTLO: r_lo <= da;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    r_hi    <= w_prod[63:32];
                    r_lo    <= w_prod[31:0];
                    r_state <= ST_DONE;
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_lo    <= w_quot;
                        r_hi    <= w_rem;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
